// File: rtl/sequencer_if.sv
// Phase-enable bundle driven by the SUBLEQ control sequencer.
// E is the execute-phase enable and F is the fetch-phase enable.
interface sequencer_if;
  logic E;
  logic F;

  modport master (output E, output F);
  modport slave  (input  E, input  F);
endinterface

// File: rtl/sequencer.sv
// Two-phase fetch/execute sequencer for the SUBLEQ datapath.
// It alternates FETCH (F high for FETCH_CYCLES edges) and EXEC (E high for
// EXEC_CYCLES edges) forever, with both enables low while in reset.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | in or just out of reset, E=0 F=0
// S_FETCH | fetch phase, F=1, counting FETCH_CYCLES edges
// S_EXEC  | execute phase, E=1, counting EXEC_CYCLES edges
module sequencer #(
  parameter int FETCH_CYCLES = 1,
  parameter int EXEC_CYCLES  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  sequencer_if.master        bus
);

  // A phase length of 0 is treated as 1, so its last count index is also 0.
  localparam logic [7:0] FC_LAST = (FETCH_CYCLES < 1) ? 8'd0 : 8'(FETCH_CYCLES - 1);
  localparam logic [7:0] EC_LAST = (EXEC_CYCLES  < 1) ? 8'd0 : 8'(EXEC_CYCLES  - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_e;
  logic       r_f;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;

  // Next-state and phase-counter decode; any unknown encoding falls back to idle.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = 8'd0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // >= rather than == so a corrupted count can never run past the phase end.
        if (r_cnt >= FC_LAST) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (r_cnt >= EC_LAST) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and enable flops; enables are registered from the next state
  // so they change together with the state and never see RST combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_e     <= 1'b0;
      r_f     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_f     <= (w_state_nxt == S_FETCH);
      r_e     <= (w_state_nxt == S_EXEC);
    end
  end

  assign bus.E = r_e;
  assign bus.F = r_f;

endmodule

// File: tb/tb_sequencer.sv
// Bench for the fetch/execute sequencer: three parameterisations share one
// clock and reset and are compared against a cycle-count reference model.
module tb_sequencer;

  logic CLK;
  logic RST;

  sequencer_if u_if0 ();
  sequencer_if u_if1 ();
  sequencer_if u_if2 ();

  sequencer #(.FETCH_CYCLES(1), .EXEC_CYCLES(1)) u_dut0 (.CLK(CLK), .RST(RST), .bus(u_if0));
  sequencer #(.FETCH_CYCLES(3), .EXEC_CYCLES(2)) u_dut1 (.CLK(CLK), .RST(RST), .bus(u_if1));
  sequencer #(.FETCH_CYCLES(0), .EXEC_CYCLES(4)) u_dut2 (.CLK(CLK), .RST(RST), .bus(u_if2));

  // Effective phase lengths (0 treated as 1).
  int fc_len [3] = '{1, 3, 1};
  int ec_len [3] = '{1, 2, 4};

  int total = 0;
  int bad   = 0;

  // Reference model: edges since the first non-reset edge.
  bit run = 0;
  int n   = 0;
  bit last_rst = 1;

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  function automatic void model_edge(input bit rst);
    last_rst = rst;
    if (rst) begin
      run = 0;
      n   = 0;
    end else if (!run) begin
      run = 1;
      n   = 0;
    end else begin
      n = n + 1;
    end
  endfunction

  function automatic bit exp_f(input int k);
    if (!run) return 1'b0;
    return ((n % (fc_len[k] + ec_len[k])) < fc_len[k]);
  endfunction

  function automatic bit exp_e(input int k);
    if (!run) return 1'b0;
    return !exp_f(k);
  endfunction

  task automatic cmp(input string tag, input int k, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e [3];
    logic f [3];
    e[0] = u_if0.E; f[0] = u_if0.F;
    e[1] = u_if1.E; f[1] = u_if1.F;
    e[2] = u_if2.E; f[2] = u_if2.F;
    for (int k = 0; k < 3; k++) begin
      cmp("F", k, f[k], exp_f(k));
      cmp("E", k, e[k], exp_e(k));
      cmp("not_both", k, e[k] & f[k], 1'b0);
      if (!last_rst) cmp("one_hot", k, e[k] | f[k], 1'b1);
    end
  endtask

  // Drive RST away from the edge, then sample 1 ns after the edge.
  task automatic tick(input bit rst);
    @(negedge CLK);
    RST = rst;
    @(posedge CLK);
    model_edge(rst);
    #1;
    check_all();
  endtask

  initial begin
    int guard;
    RST = 1'b1;

    // Power-up: edges at 10..90 ns all in reset.
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      model_edge(1'b1);
      #1;
      check_all();
    end

    // Release at 100 ns; F must rise at the 110 ns edge.
    tick(1'b0);
    cmp("powerup_F_110", 0, u_if0.F, 1'b1);
    tick(1'b0);
    cmp("powerup_E_130", 0, u_if0.E, 1'b1);
    tick(1'b0);
    cmp("powerup_F_150", 0, u_if0.F, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0);

    // Mid-operation reset while dut0 is executing.
    guard = 0;
    while (u_if0.E !== 1'b1 && guard < 4) begin
      tick(1'b0);
      guard++;
    end
    cmp("reach_exec", 0, u_if0.E, 1'b1);
    tick(1'b1);
    cmp("midrst_E", 0, u_if0.E, 1'b0);
    cmp("midrst_F", 0, u_if0.F, 1'b0);
    tick(1'b0);
    cmp("midrst_refetch", 0, u_if0.F, 1'b1);
    tick(1'b0);
    cmp("midrst_exec", 0, u_if0.E, 1'b1);

    // Ten full periods of the 3/2 configuration from a fresh release.
    tick(1'b1);
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      cmp("p32_F", 1, u_if1.F, ((i % 5) < 3) ? 1'b1 : 1'b0);
    end

    // Held reset for 20 cycles, then release.
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      cmp("held_F", 1, u_if1.F, 1'b0);
    end
    tick(1'b0);
    cmp("release_F", 1, u_if1.F, 1'b1);
    cmp("release_F_z", 2, u_if2.F, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);

    // Random reset pulses sprinkled through long runs.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound in case something stalls the clock-driven sequence.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
